// File: rtl/serial_4094_tx_pkg.sv
// rtl/serial_4094_tx_pkg.sv - shared types and defaults for the 4094 chain transmitter
//
// Purpose: state encoding, default chain geometry and a width helper shared by
// serial_4094_tx and anything that instantiates it.
// Ports: none (package).
package serial_4094_tx_pkg;

  // One 4094 per byte. Three devices on the board by default.
  localparam int DEFAULT_NUM_BYTES     = 3;
  localparam int DEFAULT_CLK_DIV       = 4;
  localparam int DEFAULT_STROBE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_GUARD    = 3'd3,
    ST_STROBE   = 3'd4
  } state_e;

  // Serial word length for a chain of num_bytes devices.
  function automatic int chain_bits(input int num_bytes);
    return 8 * num_bytes;
  endfunction

endpackage

// File: rtl/serial_4094_tx.sv
// rtl/serial_4094_tx.sv - serial master driving the 4094 shift-register chain
//
// Purpose: loads a parallel word on start, shifts it MSB-first on sclk/mosi,
// pulses strobe to latch the 4094 outputs, and captures the chain's serial
// return on miso for readback in rdata.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous, active-high
//   start   in   transfer request, honoured only when idle
//   data    in   NBITS word, bit NBITS-1 shifted first
//   busy    out  transfer in progress
//   done    out  one-cycle completion pulse, rdata valid
//   rdata   out  captured return word, first captured bit in MSB
//   sclk    out  shift clock to GLB_4094_CLK, idles low
//   mosi    out  serial data to GLB_4094_DATA
//   strobe  out  latch pulse to GLB_4094_STROBE_CTL
//   miso    in   chain serial out from the last 4094
module serial_4094_tx
  import serial_4094_tx_pkg::*;
#(
  parameter int NUM_BYTES     = DEFAULT_NUM_BYTES,
  parameter int CLK_DIV       = DEFAULT_CLK_DIV,
  parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [chain_bits(NUM_BYTES)-1:0]    data,
  output logic                                busy,
  output logic                                done,
  output logic [chain_bits(NUM_BYTES)-1:0]    rdata,
  output logic                                sclk,
  output logic                                mosi,
  output logic                                strobe,
  input  logic                                miso
);

  localparam int NBITS = chain_bits(NUM_BYTES);
  localparam int HW    = $clog2(CLK_DIV + 1);
  localparam int BW    = $clog2(NBITS + 1);
  localparam int SW    = $clog2(STROBE_CYCLES + 1);

  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(STROBE_CYCLES - 1);

  state_e             state_q,    state_d;
  logic [HW-1:0]      half_cnt_q, half_cnt_d;
  logic [BW-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [SW-1:0]      stb_cnt_q,  stb_cnt_d;
  logic [NBITS-1:0]   tx_sr_q,    tx_sr_d;
  logic [NBITS-1:0]   rx_sr_q,    rx_sr_d;
  logic [NBITS-1:0]   rdata_q,    rdata_d;
  logic               sclk_q,     sclk_d;
  logic               mosi_q,     mosi_d;
  logic               strobe_q,   strobe_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stb_cnt_d  = stb_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rdata_d    = rdata_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    strobe_d   = strobe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mosi_d = 1'b0;
        if (start) begin
          // The word is captured here, so later data changes cannot reach the wire.
          state_d    = ST_SHIFT_LO;
          tx_sr_d    = data;
          mosi_d     = data[NBITS-1];
          rx_sr_d    = '0;
          half_cnt_d = '0;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
        end
      end

      ST_SHIFT_LO: begin
        if (half_cnt_q == HALF_LAST) begin
          // mosi has been stable for a full half-period: raise sclk and take miso.
          half_cnt_d = '0;
          sclk_d     = 1'b1;
          rx_sr_d    = {rx_sr_q[NBITS-2:0], miso};
          state_d    = ST_SHIFT_HI;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      ST_SHIFT_HI: begin
        if (half_cnt_q == HALF_LAST) begin
          // mosi advances on the same edge sclk falls, keeping hold equal to setup.
          half_cnt_d = '0;
          sclk_d     = 1'b0;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_GUARD;
          end else begin
            tx_sr_d = {tx_sr_q[NBITS-2:0], 1'b0};
            mosi_d  = tx_sr_q[NBITS-2];
            state_d = ST_SHIFT_LO;
          end
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      ST_GUARD: begin
        if (half_cnt_q == HALF_LAST) begin
          half_cnt_d = '0;
          stb_cnt_d  = '0;
          strobe_d   = 1'b1;
          state_d    = ST_STROBE;
        end else begin
          half_cnt_d = half_cnt_q + 1'b1;
        end
      end

      ST_STROBE: begin
        if (stb_cnt_q == STB_LAST) begin
          strobe_d = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          mosi_d   = 1'b0;
          rdata_d  = rx_sr_q;
          state_d  = ST_IDLE;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        sclk_d   = 1'b0;
        mosi_d   = 1'b0;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Reset drops every line at once; the 4094 latches keep their old outputs
  // because strobe is never raised for a partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      half_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stb_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rdata_q    <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stb_cnt_q  <= stb_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rdata_q    <= rdata_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign strobe = strobe_q;

endmodule
